// File: rtl/dm_lsu_if.sv
// dm_lsu_if: request/response bundle between a core-side master and the
// dm_lsu data-memory load/store unit. clk/rstn are plain module ports.
interface dm_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, size, uns, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, size, uns, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/dm_lsu.sv
// dm_lsu: single-port data-memory load/store unit with byte/half/word access,
// sign/zero extension and LAT read wait states (IDLE -> WAIT -> RESP).
// Optional feature macro: DM_MISALIGN_TRAP_EN
//   defined   -> misaligned requests are trapped (no write, err=1, rdata=0)
//   undefined -> misaligned low address bits are cleared, err stays 0
module dm_lsu #(
    parameter int AW  = 7,
    parameter int LAT = 1
) (
    input  logic     clk,
    input  logic     rstn,
    dm_lsu_if.slave  bus
);
    localparam int          DEPTH    = 1 << AW;
    localparam int          LAT_M1_I = (LAT > 0) ? (LAT - 1) : 0;
    localparam logic [1:0]  LAT_M1   = LAT_M1_I[1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Memory is never reset; the first four words carry fixed start values.
    logic [31:0] mem_r [DEPTH] = '{0: 32'd2, 1: 32'd4, 2: 32'd8, 3: 32'd3, default: 32'd0};

    state_t      state_r;
    logic [1:0]  cnt_r;
    logic        ready_r;
    logic        rvalid_r;
    logic [31:0] rdata_r;
    logic        err_r;
    logic [31:0] word_r;
    logic [1:0]  off_r;
    logic [1:0]  size_r;
    logic        uns_r;

    logic [AW-1:0] idx_s;
    logic [1:0]    off_s;
    logic          trap_s;
    logic          accept_s;
    logic          st_en_s;
    logic [3:0]    be_s;
    logic [31:0]   wrep_s;
    logic          unused_s;

    // Byte-lane enables for a store of the given size at the given offset.
    function automatic logic [3:0] be_of(input logic [1:0] off, input logic [1:0] sz);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Extract byte/half from a word and sign- or zero-extend it.
    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{b[7] & ~u}}, b};
            2'b01:   r = {{16{h[15] & ~u}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign idx_s    = bus.addr[AW+1:2];
    assign unused_s = ^bus.addr[31:AW+2];
    assign accept_s = bus.req & ready_r & rstn;
    assign st_en_s  = accept_s & bus.we & ~trap_s;
    assign be_s     = be_of(off_s, bus.size);

    // Effective byte offset and misalignment trap decision.
    always_comb begin
        off_s  = bus.addr[1:0];
        trap_s = 1'b0;
`ifdef DM_MISALIGN_TRAP_EN
        case (bus.size)
            2'b00:   trap_s = 1'b0;
            2'b01:   trap_s = bus.addr[0];
            default: trap_s = (bus.addr[1:0] != 2'b00);
        endcase
`else
        case (bus.size)
            2'b00:   off_s = bus.addr[1:0];
            2'b01:   off_s = {bus.addr[1], 1'b0};
            default: off_s = 2'b00;
        endcase
`endif
    end

    // Replicate narrow store data across all lanes; byte enables pick the target.
    always_comb begin
        wrep_s = bus.wdata;
        case (bus.size)
            2'b00:   wrep_s = {4{bus.wdata[7:0]}};
            2'b01:   wrep_s = {2{bus.wdata[15:0]}};
            default: wrep_s = bus.wdata;
        endcase
    end

    // Store path: write selected byte lanes on the acceptance edge.
    always_ff @(posedge clk) begin
        if (st_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wrep_s[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered ready/rvalid/rdata/err.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= IDLE;
            cnt_r    <= 2'd0;
            ready_r  <= 1'b1;
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
            err_r    <= 1'b0;
            word_r   <= 32'd0;
            off_r    <= 2'd0;
            size_r   <= 2'd0;
            uns_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        word_r  <= mem_r[idx_s];
                        off_r   <= off_s;
                        size_r  <= bus.size;
                        uns_r   <= bus.uns;
                        ready_r <= 1'b0;
                        if (trap_s) begin
                            state_r  <= RESP;
                            rvalid_r <= 1'b1;
                            rdata_r  <= 32'd0;
                            err_r    <= 1'b1;
                        end else if (bus.we) begin
                            state_r  <= RESP;
                            rvalid_r <= 1'b1;
                            rdata_r  <= 32'd0;
                            err_r    <= 1'b0;
                        end else if (LAT == 0) begin
                            state_r  <= RESP;
                            rvalid_r <= 1'b1;
                            rdata_r  <= fmt_load(mem_r[idx_s], off_s, bus.size, bus.uns);
                            err_r    <= 1'b0;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == 2'd0) begin
                        state_r  <= RESP;
                        rvalid_r <= 1'b1;
                        rdata_r  <= fmt_load(word_r, off_r, size_r, uns_r);
                        err_r    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                RESP: begin
                    state_r  <= IDLE;
                    ready_r  <= 1'b1;
                    rvalid_r <= 1'b0;
                    rdata_r  <= 32'd0;
                    err_r    <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= 2'd0;
                    ready_r  <= 1'b1;
                    rvalid_r <= 1'b0;
                    rdata_r  <= 32'd0;
                    err_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready  = ready_r;
    assign bus.rvalid = rvalid_r;
    assign bus.rdata  = rdata_r;
    assign bus.err    = err_r;
endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: table-driven scoreboard bench for dm_lsu (LAT=1 instance) plus a
// LAT=3 instance for back-pressure and mid-transaction reset sequences.
module tb_dm_lsu;
    logic clk;
    logic rstn;
    logic rstn3;

    dm_lsu_if bus();
    dm_lsu_if bus3();

    dm_lsu #(.AW(7), .LAT(1)) dut  (.clk(clk), .rstn(rstn),  .bus(bus));
    dm_lsu #(.AW(7), .LAT(3)) dut3 (.clk(clk), .rstn(rstn3), .bus(bus3));

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    exp_t sb_q[$];
    exp_t sb3_q[$];
    vec_t vecs[23];

    int chk_cnt = 0;
    int err_cnt = 0;
    logic mon_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor for the LAT=1 instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.rvalid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rdata", bus.rdata, e.rdata);
                    check("err", {31'd0, bus.err}, {31'd0, e.err});
                end
            end else begin
                check("idle_rdata", bus.rdata, 32'd0);
                check("idle_err", {31'd0, bus.err}, 32'd0);
            end
        end
    end

    // Response monitor for the LAT=3 instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus3.rvalid === 1'b1) begin
                if (sb3_q.size() == 0) begin
                    check("unexpected_rvalid3", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb3_q.pop_front();
                    check("rdata3", bus3.rdata, e.rdata);
                    check("err3", {31'd0, bus3.err}, {31'd0, e.err});
                end
            end else begin
                check("idle_rdata3", bus3.rdata, 32'd0);
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic u, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            bus.req = 1'b1; bus.we = w; bus.addr = a; bus.size = s; bus.uns = u; bus.wdata = wd;
            @(posedge clk);
            e.rdata = er;
            e.err   = ee;
            sb_q.push_back(e);
            #1 bus.req = 1'b0;
        end
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((sb_q.size() != 0 || sb3_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int acc;
        int rv;
        int low_run;
        exp_t e;

        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int rv;
        int low_run;
        exp_t e;

        // we, addr, size, uns, wdata, expected rdata, expected err
        vecs[0]  = '{1'b0, 32'h0000_0000, 2'b10, 1'b0, 32'h0,          32'h0000_0002, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0005, 2'b00, 1'b0, 32'h1234_56AB,  32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0004, 2'b10, 1'b0, 32'h0,          32'h0000_AB04, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0005, 2'b00, 1'b0, 32'h0,          32'hFFFF_FFAB, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0005, 2'b00, 1'b1, 32'h0,          32'h0000_00AB, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0002, 2'b01, 1'b0, 32'hDEAD_8001,  32'h0,         1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0002, 2'b01, 1'b0, 32'h0,          32'hFFFF_8001, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0002, 2'b01, 1'b1, 32'h0,          32'h0000_8001, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0000, 2'b01, 1'b0, 32'h0,          32'h0000_0002, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0000, 2'b10, 1'b0, 32'h0,          32'h8001_0002, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_01FC, 2'b10, 1'b0, 32'hCAFE_F00D,  32'h0,         1'b0};
        vecs[11] = '{1'b0, 32'h0000_01FC, 2'b10, 1'b0, 32'h0,          32'hCAFE_F00D, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_0200, 2'b10, 1'b0, 32'h0,          32'h8001_0002, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_01FF, 2'b00, 1'b0, 32'h0,          32'hFFFF_FFCA, 1'b0};
        vecs[14] = '{1'b0, 32'h0000_01FE, 2'b00, 1'b1, 32'h0,          32'h0000_00FE, 1'b0};
        vecs[15] = '{1'b1, 32'h0000_000F, 2'b00, 1'b0, 32'h0000_007F,  32'h0,         1'b0};
        vecs[16] = '{1'b0, 32'h0000_000C, 2'b10, 1'b0, 32'h0,          32'h7F00_0003, 1'b0};
        vecs[17] = '{1'b0, 32'h0000_000F, 2'b00, 1'b0, 32'h0,          32'h0000_007F, 1'b0};
        vecs[18] = '{1'b1, 32'h0000_000E, 2'b01, 1'b0, 32'h0000_1234,  32'h0,         1'b0};
        vecs[19] = '{1'b0, 32'h0000_000C, 2'b10, 1'b0, 32'h0,          32'h1234_0003, 1'b0};
        vecs[20] = '{1'b0, 32'h0000_000E, 2'b01, 1'b0, 32'h0,          32'h0000_1234, 1'b0};
        vecs[21] = '{1'b0, 32'h0000_000C, 2'b11, 1'b0, 32'h0,          32'h1234_0003, 1'b0};
        vecs[22] = '{1'b0, 32'hFFFF_FE08, 2'b10, 1'b0, 32'h0,          32'h0000_0008, 1'b0};

        rstn = 1'b0; rstn3 = 1'b0;
        bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = 32'd0;  bus.size = 2'b10;  bus.uns = 1'b0;  bus.wdata = 32'd0;
        bus3.req = 1'b0; bus3.we = 1'b0; bus3.addr = 32'd0; bus3.size = 2'b10; bus3.uns = 1'b0; bus3.wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_ready3", {31'd0, bus3.ready}, 32'd1);
        rstn = 1'b1; rstn3 = 1'b1;
        mon_en = 1'b1;

        // Load word 0x8 with LAT=1: response in the second cycle after acceptance.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h8; bus.size = 2'b10; bus.uns = 1'b0;
        @(posedge clk);
        e.rdata = 32'h8; e.err = 1'b0;
        sb_q.push_back(e);
        #1 bus.req = 1'b0;
        @(negedge clk);
        check("lat_cycle1_rvalid", {31'd0, bus.rvalid}, 32'd0);
        @(negedge clk);
        check("lat_cycle2_rvalid", {31'd0, bus.rvalid}, 32'd1);

        // Misaligned accesses before memory is modified.
`ifdef DM_MISALIGN_TRAP_EN
        issue(1'b0, 32'h6, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        issue(1'b0, 32'h9, 2'b01, 1'b1, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 32'h7, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        issue(1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 32'h4, 1'b0);
`else
        issue(1'b0, 32'h6, 2'b10, 1'b0, 32'h0, 32'h4, 1'b0);
        issue(1'b0, 32'h9, 2'b01, 1'b1, 32'h0, 32'h8, 1'b0);
`endif

        for (int i = 0; i < 23; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                  vecs[i].rdata, vecs[i].err);
        end
        drain();

        // LAT=3 with req held high: one accept per 5 cycles, ready low for 4.
        acc = 0; rv = 0; low_run = 0;
        @(negedge clk);
        bus3.req = 1'b1; bus3.we = 1'b0; bus3.addr = 32'h8; bus3.size = 2'b10; bus3.uns = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (bus3.rvalid === 1'b1) rv++;
            if (bus3.ready === 1'b1) begin
                if (acc > 0) check("lat3_ready_low_run", low_run, 32'd4);
                acc++;
                low_run = 0;
                e.rdata = 32'h8; e.err = 1'b0;
                sb3_q.push_back(e);
            end else begin
                low_run++;
            end
            if (k < 24) @(negedge clk);
        end
        bus3.req = 1'b0;
        drain();
        check("lat3_accepts", acc, 32'd5);
        check("lat3_rvalids", rv, 32'd5);

        // Reset while in WAIT: immediate idle outputs and no response.
        @(negedge clk);
        bus3.req = 1'b1; bus3.addr = 32'h0;
        @(posedge clk);
        #1 bus3.req = 1'b0;
        @(negedge clk);
        check("wait_ready_low", {31'd0, bus3.ready}, 32'd0);
        #1 rstn3 = 1'b0;
        #1;
        check("rst_wait_ready", {31'd0, bus3.ready}, 32'd1);
        check("rst_wait_rvalid", {31'd0, bus3.rvalid}, 32'd0);
        check("rst_wait_rdata", bus3.rdata, 32'd0);
        repeat (2) @(negedge clk);
        rstn3 = 1'b1;
        rv = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus3.rvalid === 1'b1) rv++;
        end
        check("rst_no_response", rv, 32'd0);

        // Subsequent load on the reset instance works normally.
        bus3.req = 1'b1; bus3.addr = 32'hC; bus3.size = 2'b10;
        @(posedge clk);
        e.rdata = 32'h3; e.err = 1'b0;
        sb3_q.push_back(e);
        #1 bus3.req = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule
